// File: rtl/decoder_4_16_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_pkg
//  Purpose  : Shared widths, FSM state type and one-hot helper for the
//             4-to-16 sequenced decoder.
//  Revision : 1.0  initial release
// ============================================================================
package decoder_pkg;

  localparam int CODE_W = 4;
  localparam int OUT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } dec_state_t;

  // Single 1 at bit position 'code'.
  function automatic logic [OUT_W-1:0] onehot16(input logic [CODE_W-1:0] code);
    return OUT_W'(1) << code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_4_16_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_4_16_seq_if
//  Purpose  : Handshake and output bundle of the sequenced 4-to-16 decoder.
//             master = the agent driving codes/scans, slave = the decoder.
//  Revision : 1.0  initial release
// ============================================================================
interface decoder_4_16_seq_if;
  import decoder_pkg::*;

  logic              enable;
  logic [CODE_W-1:0] code;
  logic              in_valid;
  logic              in_ready;
  logic              scan_start;
  logic [OUT_W-1:0]  o;
  logic              o_valid;
  logic              busy;
  logic              scan_done;

  modport master (
    output enable, code, in_valid, scan_start,
    input  in_ready, o, o_valid, busy, scan_done
  );

  modport slave (
    input  enable, code, in_valid, scan_start,
    output in_ready, o, o_valid, busy, scan_done
  );

endinterface
`default_nettype wire

// File: rtl/decoder_4_16_core.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_4_16_core
//  Purpose  : Combinational 4-to-16 one-hot decode with an enable gate.
//  Revision : 1.0  initial release
// ============================================================================
module decoder_4_16_core
  import decoder_pkg::*;
(
  input  logic              i_enable,
  input  logic [CODE_W-1:0] i_code,
  output logic [OUT_W-1:0]  o_onehot
);

  // Gate the decoded word so a disabled core never presents an active line.
  always_comb begin
    o_onehot = '0;
    if (i_enable) begin
      o_onehot = onehot16(i_code);
    end
  end

endmodule
`default_nettype wire

// File: rtl/decoder_4_16_seq.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_4_16_seq
//  Purpose  : Registered 4-to-16 one-hot decoder with valid/ready input and
//             a scan sequencer that walks a single 1 across all 16 lines,
//             holding each line for SCAN_HOLD cycles.
//  Revision : 1.0  initial release
// ============================================================================
module decoder_4_16_seq
  import decoder_pkg::*;
#(
  parameter int SCAN_HOLD = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  decoder_4_16_seq_if.slave   bus
);

  localparam int                  HOLD_W    = $clog2(SCAN_HOLD + 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);
  localparam logic [CODE_W-1:0]   IDX_LAST  = CODE_W'(OUT_W - 1);

  dec_state_t        state_q, state_d;
  logic [CODE_W-1:0] idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [OUT_W-1:0]  o_q, o_d;
  logic              o_valid_q, o_valid_d;
  logic              busy_q, busy_d;
  logic              scan_done_q, scan_done_d;

  logic              w_in_ready;
  logic              w_scan_sel;
  logic [CODE_W-1:0] w_scan_code;
  logic [CODE_W-1:0] w_dec_code;
  logic [OUT_W-1:0]  w_dec_onehot;

  // Ready only in IDLE; a simultaneous scan request takes precedence.
  assign w_in_ready   = bus.enable && (state_q == IDLE) && !bus.scan_start;
  assign bus.in_ready = w_in_ready;

  // Shared decoder input: scan position (0 on start, next index while
  // scanning) or the accepted input code.
  assign w_scan_sel  = (state_q != IDLE) || bus.scan_start;
  assign w_scan_code = (state_q == IDLE) ? '0 : (idx_q + 1'b1);
  assign w_dec_code  = w_scan_sel ? w_scan_code : bus.code;

  decoder_4_16_core u_core (
    .i_enable (bus.enable),
    .i_code   (w_dec_code),
    .o_onehot (w_dec_onehot)
  );

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    o_d         = o_q;
    o_valid_d   = o_valid_q;
    scan_done_d = 1'b0;

    if (!bus.enable) begin
      // Disable aborts everything, including a scan, with no done pulse.
      state_d   = IDLE;
      idx_d     = '0;
      hold_d    = '0;
      o_d       = '0;
      o_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.scan_start) begin
            state_d   = SCAN;
            idx_d     = '0;
            hold_d    = '0;
            o_d       = w_dec_onehot;
            o_valid_d = 1'b1;
          end else if (bus.in_valid && w_in_ready) begin
            o_d       = w_dec_onehot;
            o_valid_d = 1'b1;
          end
        end
        SCAN: begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (idx_q != IDX_LAST) begin
              idx_d = idx_q + 1'b1;
              o_d   = w_dec_onehot;
            end else begin
              state_d     = DONE;
              o_d         = '0;
              o_valid_d   = 1'b0;
              scan_done_d = 1'b1;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
          idx_d   = '0;
          hold_d  = '0;
        end
        default: begin
          state_d   = IDLE;
          idx_d     = '0;
          hold_d    = '0;
          o_d       = '0;
          o_valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hold_q      <= '0;
      o_q         <= '0;
      o_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      o_q         <= o_d;
      o_valid_q   <= o_valid_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign bus.o         = o_q;
  assign bus.o_valid   = o_valid_q;
  assign bus.busy      = busy_q;
  assign bus.scan_done = scan_done_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_4_16_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_4_16_seq
//  Purpose  : Self-checking bench for decoder_4_16_seq: directed scenarios
//             followed by random stimulus against a timeline model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decoder_4_16_seq;

  localparam int H = 2;

  logic clk;
  logic rst_n;
  decoder_4_16_seq_if bus ();

  decoder_4_16_seq #(.SCAN_HOLD(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: a scan is described by the number of edges since it
  // started; outputs follow directly from that count.
  bit          m_scan;
  int          m_t;
  logic [15:0] m_o;
  logic        m_valid;
  logic        m_busy;
  logic        m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan  = 1'b0;
    m_t     = 0;
    m_o     = 16'h0;
    m_valid = 1'b0;
    m_busy  = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic [3:0] c, input logic iv, input logic ss);
    if (!en) begin
      model_reset();
    end else if (m_scan) begin
      m_t++;
      if (m_t < 16 * H) begin
        m_o = 16'(1 << (m_t / H)); m_valid = 1'b1; m_busy = 1'b1; m_done = 1'b0;
      end else if (m_t == 16 * H) begin
        m_o = 16'h0; m_valid = 1'b0; m_busy = 1'b1; m_done = 1'b1;
      end else begin
        m_scan = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      m_busy = 1'b0;
      if (ss) begin
        m_scan = 1'b1; m_t = 0; m_o = 16'h0001; m_valid = 1'b1; m_busy = 1'b1;
      end else if (iv) begin
        m_o = 16'(1 << c); m_valid = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".o"},         32'(bus.o),         32'(m_o));
    chk({tag, ".o_valid"},   32'(bus.o_valid),   32'(m_valid));
    chk({tag, ".busy"},      32'(bus.busy),      32'(m_busy));
    chk({tag, ".scan_done"}, 32'(bus.scan_done), 32'(m_done));
  endtask

  // One clock: drive inputs away from the edge, check in_ready, clock, check registers.
  task automatic step(input logic en, input logic [3:0] c, input logic iv, input logic ss, input string tag);
    logic exp_rdy;
    @(negedge clk);
    bus.enable = en; bus.code = c; bus.in_valid = iv; bus.scan_start = ss;
    #1;
    exp_rdy = en && !m_scan && !ss;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    model_edge(en, c, iv, ss);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int busy_cnt;
    n_vec = 0;
    n_err = 0;
    model_reset();
    bus.enable = 1'b0; bus.code = 4'h0; bus.in_valid = 1'b0; bus.scan_start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    step(1'b1, 4'h0, 1'b0, 1'b0, "idle");

    // Single-shot decodes, including back-to-back extremes.
    step(1'b1, 4'hA, 1'b1, 1'b0, "accA");
    chk("accA.const", 32'(bus.o), 32'h0400);
    step(1'b1, 4'h0, 1'b1, 1'b0, "acc0");
    chk("acc0.const", 32'(bus.o), 32'h0001);
    step(1'b1, 4'hF, 1'b1, 1'b0, "accF");
    chk("accF.const", 32'(bus.o), 32'h8000);

    // Full scan with timeline and busy-length checks.
    busy_cnt = 0;
    step(1'b1, 4'h0, 1'b0, 1'b1, "scan0");
    if (bus.busy) busy_cnt++;
    for (int k = 1; k <= 33; k++) begin
      step(1'b1, 4'h0, 1'b0, 1'b0, "scan");
      if (bus.busy) busy_cnt++;
      if (k < 32) chk("scan.code", 32'(bus.o), 32'(1 << (k / 2)));
      if (k == 32) chk("scan.done_pulse", 32'(bus.scan_done), 32'd1);
    end
    chk("scan.busy_len", 32'(busy_cnt), 32'd33);

    // scan_start beats in_valid.
    step(1'b1, 4'h3, 1'b1, 1'b1, "prio");
    chk("prio.const", 32'(bus.o), 32'h0001);

    // Continue to index 7, then drop enable.
    for (int k = 1; k <= 14; k++) step(1'b1, 4'h3, 1'b1, 1'b1, "to7");
    chk("to7.const", 32'(bus.o), 32'h0080);
    step(1'b0, 4'h0, 1'b0, 1'b0, "abort");
    chk("abort.o", 32'(bus.o), 32'h0);
    for (int k = 0; k < 3; k++) step(1'b1, 4'h0, 1'b0, 1'b0, "post_abort");

    // Asynchronous reset mid-scan.
    step(1'b1, 4'h0, 1'b0, 1'b1, "rscan");
    for (int k = 0; k < 5; k++) step(1'b1, 4'h0, 1'b0, 1'b0, "rscan");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'h5, 1'b1, 1'b0, "acc5");
    chk("acc5.const", 32'(bus.o), 32'h0020);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) < 96) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
           "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
